// File: rtl/coordic_vector_prep.sv
// Input conditioning for a CORDIC vectoring core: folds (x, y) into the right
// half-plane, pre-scales it below 2^LIMIT_EXP, then issues it with a start pulse.
module coordic_vector_prep #(
  parameter int n         = 16,
  parameter int LIMIT_EXP = n - 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [n-1:0] x_in,
  input  logic signed [n-1:0] y_in,
  output logic                st,
  output logic signed [n-1:0] x_out,
  output logic signed [n-1:0] y_out,
  output logic [1:0]          quad,
  output logic [1:0]          shift,
  input  logic                core_done,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLD,
    S_SCALE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic signed [n:0] LIM_POS = (n+1)'(2 ** LIMIT_EXP);
  localparam logic signed [n:0] LIM_NEG = -LIM_POS;

  state_t               state_q;
  // One guard bit so that -2^(n-1) folds to +2^(n-1) without wrapping.
  logic signed [n:0]    x_q, y_q;
  logic [1:0]           cnt_q;
  logic [1:0]           fold_quad_q;
  logic                 st_q;
  logic signed [n-1:0]  x_out_q, y_out_q;
  logic [1:0]           quad_q, shift_q;
  logic                 over_lim_d;

  assign over_lim_d = (x_q >= LIM_POS) || (x_q <= LIM_NEG) ||
                      (y_q >= LIM_POS) || (y_q <= LIM_NEG);

  // NOTE: every register here, outputs included, is updated with non-blocking
  // assignments so all state advances together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      fold_quad_q <= '0;
      st_q        <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      quad_q      <= '0;
      shift_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q     <= {x_in[n-1], x_in};
            y_q     <= {y_in[n-1], y_in};
            cnt_q   <= '0;
            state_q <= S_FOLD;
          end
        end

        S_FOLD: begin
          if (x_q[n]) begin
            x_q         <= -x_q;
            y_q         <= -y_q;
            fold_quad_q <= y_q[n] ? 2'b10 : 2'b01;
          end else begin
            fold_quad_q <= 2'b00;
          end
          state_q <= S_SCALE;
        end

        S_SCALE: begin
          // The count cap only matters for a LIMIT_EXP below n-3.
          if (over_lim_d && cnt_q != 2'd3) begin
            x_q   <= x_q >>> 1;
            y_q   <= y_q >>> 1;
            cnt_q <= cnt_q + 2'd1;
          end else begin
            st_q    <= 1'b1;
            x_out_q <= x_q[n-1:0];
            y_out_q <= y_q[n-1:0];
            quad_q  <= fold_quad_q;
            shift_q <= cnt_q;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          st_q    <= 1'b0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (core_done) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign st       = st_q;
  assign x_out    = x_out_q;
  assign y_out    = y_out_q;
  assign quad     = quad_q;
  assign shift    = shift_q;

endmodule

// File: tb/tb_coordic_vector_prep.sv
// Self-checking bench for coordic_vector_prep: directed vector table, corner
// sequences (backpressure, reset mid-run, forced floor shift) and random samples.
module tb_coordic_vector_prep;

  localparam int N = 16;

  typedef struct {
    int x;
    int y;
    int xo;
    int yo;
    int q;
    int s;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid, core_done;
  logic                in_ready, st, busy;
  logic signed [N-1:0] x_in, y_in, x_out, y_out;
  logic [1:0]          quad, shift;

  logic                in_valid6, core_done6;
  logic                in_ready6, st6, busy6;
  logic signed [N-1:0] x_in6, y_in6, x_out6, y_out6;
  logic [1:0]          quad6, shift6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  coordic_vector_prep #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .st(st), .x_out(x_out), .y_out(y_out),
    .quad(quad), .shift(shift), .core_done(core_done), .busy(busy)
  );

  coordic_vector_prep #(.n(N), .LIMIT_EXP(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .x_in(x_in6), .y_in(y_in6), .st(st6), .x_out(x_out6), .y_out(y_out6),
    .quad(quad6), .shift(shift6), .core_done(core_done6), .busy(busy6)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_half(input int v);
    return (v >= 0) ? v / 2 : -((-v + 1) / 2);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: fold to right half-plane, then halve (floor) until inside the limit.
  function automatic vec_t model(input int x, input int y, input int lim_exp);
    vec_t r;
    int   lim;
    lim  = 1 << lim_exp;
    r.x  = x;
    r.y  = y;
    r.q  = 0;
    r.s  = 0;
    if (x < 0) begin
      r.q = (y >= 0) ? 1 : 2;
      x   = -x;
      y   = -y;
    end
    while (iabs(x) >= lim || iabs(y) >= lim) begin
      x = floor_half(x);
      y = floor_half(y);
      r.s++;
    end
    r.xo = x;
    r.yo = y;
    return r;
  endfunction

  // Watches the cycles following an acceptance edge (called #1 after it).
  task automatic observe(input vec_t v, input string tag);
    int   st_cnt;
    int   st_cyc;
    logic busy_ok;
    st_cnt  = 0;
    st_cyc  = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (st) begin
        st_cnt++;
        st_cyc = c;
      end
      if (!busy || in_ready) busy_ok = 1'b0;
    end
    check({tag, " st_pulses"}, st_cnt, 1);
    check({tag, " st_cycle"}, st_cyc, 3 + v.s);
    check({tag, " busy_held"}, busy_ok, 1);
    check({tag, " x_out"}, x_out, v.xo);
    check({tag, " y_out"}, y_out, v.yo);
    check({tag, " quad"}, quad, v.q);
    check({tag, " shift"}, shift, v.s);
  endtask

  task automatic finish_core(input string tag);
    @(negedge clk);
    core_done = 1'b1;
    @(posedge clk);
    #1 core_done = 1'b0;
    @(negedge clk);
    check({tag, " idle_after_done"}, {busy, in_ready}, 2'b01);
  endtask

  task automatic send(input vec_t v, input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready_before_send"}, in_ready, 1);
    in_valid = 1'b1;
    x_in     = N'(v.x);
    y_in     = N'(v.y);
    @(posedge clk);
    #1 in_valid = 1'b0;
    observe(v, tag);
  endtask

  vec_t table_v[9];
  vec_t v, w;

  initial begin
    table_v[0] = '{x:  1000,  y:   500, xo: 1000, yo:  500, q: 0, s: 0};
    table_v[1] = '{x: -8192,  y:   100, xo: 4096, yo:  -50, q: 1, s: 1};
    table_v[2] = '{x: -32768, y: -32768, xo: 4096, yo: 4096, q: 2, s: 3};
    table_v[3] = '{x:     0,  y:     0, xo:    0, yo:    0, q: 0, s: 0};
    table_v[4] = '{x:  8191,  y: -8192, xo: 4095, yo: -4096, q: 0, s: 1};
    table_v[5] = '{x:    -1,  y:     0, xo:    1, yo:    0, q: 1, s: 0};
    table_v[6] = '{x:    -5,  y:    -7, xo:    5, yo:    7, q: 2, s: 0};
    table_v[7] = '{x: 32767,  y:     0, xo: 8191, yo:    0, q: 0, s: 2};
    table_v[8] = '{x:     3,  y:     4, xo:    3, yo:    4, q: 0, s: 0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    core_done  = 1'b0;
    x_in       = '0;
    y_in       = '0;
    in_valid6  = 1'b0;
    core_done6 = 1'b0;
    x_in6      = '0;
    y_in6      = '0;

    repeat (2) @(negedge clk);
    check("reset st", st, 0);
    check("reset busy/ready", {busy, in_ready}, 2'b01);
    check("reset x_out", x_out, 0);
    check("reset y_out", y_out, 0);
    check("reset quad/shift", {quad, shift}, 4'b0000);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send(table_v[i], $sformatf("vec%0d", i));
      finish_core($sformatf("vec%0d", i));
    end

    // Backpressure: second sample offered during WAIT must not be taken.
    v = table_v[0];
    w = table_v[6];
    send(v, "bp_first");
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = N'(w.x);
    y_in     = N'(w.y);
    repeat (3) @(negedge clk);
    check("bp ready_low", in_ready, 0);
    check("bp busy", busy, 1);
    check("bp x_hold", x_out, v.xo);
    check("bp y_hold", y_out, v.yo);
    core_done = 1'b1;
    @(posedge clk);
    #1 core_done = 1'b0;
    @(negedge clk);
    check("bp ready_after_done", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    observe(w, "bp_second");
    finish_core("bp_second");

    // Stray completion while idle changes nothing.
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    check("stray busy/ready", {busy, in_ready}, 2'b01);
    check("stray st", st, 0);
    check("stray x_hold", x_out, w.xo);

    // Reset during SCALE of (-32768, 0).
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = -16'sd32768;
    y_in     = 16'sd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid st", st, 0);
    check("rst_mid x_out", x_out, 0);
    check("rst_mid y_out", y_out, 0);
    check("rst_mid quad/shift", {quad, shift}, 4'b0000);
    check("rst_mid busy/ready", {busy, in_ready}, 2'b01);
    begin
      int st_seen;
      st_seen = 0;
      core_done = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (st) st_seen++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (st) st_seen++;
      end
      core_done = 1'b0;
      check("rst_mid no_st", st_seen, 0);
      check("rst_mid idle_after", {busy, in_ready}, 2'b01);
    end
    send(table_v[8], "post_rst");
    finish_core("post_rst");

    // Random samples against the reference model.
    for (int i = 0; i < 200; i++) begin
      int rx, ry;
      rx = int'($signed(16'($urandom)));
      ry = int'($signed(16'($urandom)));
      if (i % 17 == 0) rx = -32768;
      if (i % 23 == 0) ry = -32768;
      send(model(rx, ry, N - 3), $sformatf("rnd%0d(%0d,%0d)", i, rx, ry));
      finish_core($sformatf("rnd%0d", i));
    end

    // Forced floor shift with LIMIT_EXP = 6.
    begin
      int   st_cyc;
      vec_t e;
      e      = model(0, -101, 6);
      st_cyc = -1;
      @(negedge clk);
      check("lim6 ready", in_ready6, 1);
      in_valid6 = 1'b1;
      x_in6     = 16'sd0;
      y_in6     = -16'sd101;
      @(posedge clk);
      #1 in_valid6 = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        if (st6 && st_cyc < 0) st_cyc = c;
      end
      check("lim6 st_cycle", st_cyc, 4);
      check("lim6 x_out", x_out6, 0);
      check("lim6 y_out", y_out6, -51);
      check("lim6 model_y", y_out6, e.yo);
      check("lim6 quad", quad6, 0);
      check("lim6 shift", shift6, 1);
      core_done6 = 1'b1;
      @(negedge clk);
      core_done6 = 1'b0;
      @(negedge clk);
      check("lim6 idle", {busy6, in_ready6}, 2'b01);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
